// File: rtl/vga_frame_scanner.sv
// Raster scanner for the 3-bit frame buffer: VGA timing, a raster-order read address,
// and 1-bit-per-channel colour expanded to 10-bit DAC codes, with sync/blank delayed to match.
module vga_frame_scanner #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int ADDR_W   = 19,
   parameter int COLOR_W  = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pix_en,
   output logic [ADDR_W-1:0]  rdaddress,
   input  logic [COLOR_W-1:0] q,
   output logic [9:0]         vga_r,
   output logic [9:0]         vga_g,
   output logic [9:0]         vga_b,
   output logic               vga_hs_n,
   output logic               vga_vs_n,
   output logic               vga_blank_n,
   output logic               frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0]     H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_ACT     = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_FIRST  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0]     V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_ACT     = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_FIRST  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   logic [HW-1:0]      hc_q, hc_d;
   logic [VW-1:0]      vc_q, vc_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic               active0, hs0, vs0;
   logic               active_d1_q, hs_d1_q, vs_d1_q;
   logic               active_d2_q, hs_d2_q, vs_d2_q;
   logic [9:0]         r_q, g_q, b_q;
   logic               fs_q;
   logic               tick_d1_q;
   logic [COLOR_W-1:0] pix_q, pix_sel;

   always_comb begin
      active0 = (hc_q < H_ACT) && (vc_q < V_ACT);
      hs0     = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
      vs0     = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
      hc_d    = hc_q + 1'b1;
      vc_d    = vc_q;
      if (hc_q == H_LAST) begin
         hc_d = '0;
         vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end
      addr_d = addr_q;
      if ((hc_q == H_LAST) && (vc_q == V_LAST))
         addr_d = '0;
      else if (active0 && (addr_q != ADDR_LAST))
         addr_d = addr_q + 1'b1;
      // Buffer data for the previous tick's address is final one clk after that tick;
      // use it live when the ticks are back-to-back, otherwise the copy captured then.
      pix_sel = tick_d1_q ? q : pix_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc_q        <= '0;
         vc_q        <= '0;
         addr_q      <= '0;
         active_d1_q <= 1'b0;
         hs_d1_q     <= 1'b0;
         vs_d1_q     <= 1'b0;
         active_d2_q <= 1'b0;
         hs_d2_q     <= 1'b0;
         vs_d2_q     <= 1'b0;
         r_q         <= '0;
         g_q         <= '0;
         b_q         <= '0;
         fs_q        <= 1'b0;
         tick_d1_q   <= 1'b0;
         pix_q       <= '0;
      end else begin
         fs_q      <= pix_en && (hc_q == '0) && (vc_q == '0);
         tick_d1_q <= pix_en;
         if (tick_d1_q)
            pix_q <= q;
         if (pix_en) begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            addr_q      <= addr_d;
            active_d1_q <= active0;
            hs_d1_q     <= hs0;
            vs_d1_q     <= vs0;
            active_d2_q <= active_d1_q;
            hs_d2_q     <= hs_d1_q;
            vs_d2_q     <= vs_d1_q;
            if (active_d1_q) begin
               r_q <= {10{pix_sel[2]}};
               g_q <= {10{pix_sel[1]}};
               b_q <= {10{pix_sel[0]}};
            end else begin
               r_q <= '0;
               g_q <= '0;
               b_q <= '0;
            end
         end
      end
   end

   assign rdaddress   = addr_q;
   assign vga_r       = r_q;
   assign vga_g       = g_q;
   assign vga_b       = b_q;
   assign vga_hs_n    = ~hs_d2_q;
   assign vga_vs_n    = ~vs_d2_q;
   assign vga_blank_n = active_d2_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Bench for vga_frame_scanner: a full-size 640x480 instance and a shrunken-geometry instance
// run side by side, each fed by a 1-clk-latency buffer model and checked against an arithmetic raster model.
module tb_vga_frame_scanner;

   typedef struct {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp;
   } geom_t;

   typedef struct {
      int          n;
      logic [18:0] addr;
      logic [9:0]  r, g, b;
      logic        hs_n, blank_n;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pix_en = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] rd_l, rd_s;
   logic [2:0]  q_l = '0, q_s = '0;
   logic [9:0]  r_l, g_l, b_l, r_s, g_s, b_s;
   logic        hs_l, vs_l, bl_l, fs_l, hs_s, vs_s, bl_s, fs_s;

   vga_frame_scanner dut_l (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rdaddress(rd_l), .q(q_l),
      .vga_r(r_l), .vga_g(g_l), .vga_b(b_l), .vga_hs_n(hs_l), .vga_vs_n(vs_l),
      .vga_blank_n(bl_l), .frame_start(fs_l)
   );

   vga_frame_scanner #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .rdaddress(rd_s), .q(q_s),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs_n(hs_s), .vga_vs_n(vs_s),
      .vga_blank_n(bl_s), .frame_start(fs_s)
   );

   int mode = 0;   // 0: q = addr[2:0], 1: q = 3'b111, 2: hashed contents
   int seed = 0;
   int n = 0;      // pix_en ticks since reset release
   bit last_tick = 1'b0;
   int checks = 0;
   int errors = 0;
   geom_t gl, gs;

   function automatic logic [2:0] mem_f(logic [18:0] a);
      int x;
      if (mode == 0) x = int'(a);
      else if (mode == 1) x = 7;
      else x = (int'(a) * 37) ^ (int'(a) >> 4) ^ seed;
      return 3'(x & 7);
   endfunction

   always @(posedge clk) begin
      q_l <= mem_f(rd_l);
      q_s <= mem_f(rd_s);
   end

   // Number of visible pixels before frame position f, saturated at the last valid address.
   function automatic int addr_at(geom_t g, int f);
      int ht, hc, vc, cnt;
      ht = g.ha + g.hfp + g.hs + g.hbp;
      hc = f % ht;
      vc = f / ht;
      cnt = (vc < g.va) ? vc * g.ha + ((hc < g.ha) ? hc : g.ha) : g.ha * g.va;
      return (cnt > g.ha * g.va - 1) ? g.ha * g.va - 1 : cnt;
   endfunction

   function automatic logic [52:0] expect_v(geom_t g, int cnt, bit fs_tick);
      int ht, vt, fr, f, hc, vc;
      bit act, hs, vs, fs;
      logic [2:0]  px;
      logic [9:0]  r, gg, b;
      logic [18:0] ad;
      ht = g.ha + g.hfp + g.hs + g.hbp;
      vt = g.va + g.vfp + g.vs + g.vbp;
      fr = ht * vt;
      ad = 19'(addr_at(g, cnt % fr));
      fs = fs_tick && (((cnt - 1) % fr) == 0);
      if (cnt < 2) return {ad, 30'b0, 1'b1, 1'b1, 1'b0, fs};
      f   = (cnt - 2) % fr;
      hc  = f % ht;
      vc  = f / ht;
      act = (hc < g.ha) && (vc < g.va);
      hs  = (hc >= g.ha + g.hfp) && (hc < g.ha + g.hfp + g.hs);
      vs  = (vc >= g.va + g.vfp) && (vc < g.va + g.vfp + g.vs);
      r = '0; gg = '0; b = '0;
      if (act) begin
         px = mem_f(19'(addr_at(g, f)));
         r  = {10{px[2]}};
         gg = {10{px[1]}};
         b  = {10{px[0]}};
      end
      return {ad, r, gg, b, ~hs, ~vs, act, fs};
   endfunction

   task automatic cmp(input string nm, input logic [52:0] act, input logic [52:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d actual=%h required=%h", nm, n, act, exp);
      end
   endtask

   task automatic cmp_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      cmp({tag, "_large"}, {rd_l, r_l, g_l, b_l, hs_l, vs_l, bl_l, fs_l}, expect_v(gl, n, last_tick));
      cmp({tag, "_small"}, {rd_s, r_s, g_s, b_s, hs_s, vs_s, bl_s, fs_s}, expect_v(gs, n, last_tick));
   endtask

   task automatic step(input bit en);
      @(negedge clk);
      pix_en = en;
      @(posedge clk);
      #1;
      last_tick = rst_n && en;
      if (last_tick) n++;
      check_all("step");
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      n = 0;
      last_tick = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1);
      @(negedge clk);
      pix_en = 1'b0;
      rst_n = 1'b1;
   endtask

   vec_t tab[13];
   int hs_low, vs_low, fs_cnt_l, fs_cnt_s, bad_mask, blank_seen;

   task automatic tick_a();
      step(1'b1);
      if (n >= 800 && n < 1600 && !hs_l) hs_low++;
      if (n >= 250 && n < 500 && !vs_s) vs_low++;
      if (fs_l) fs_cnt_l++;
      if (fs_s) fs_cnt_s++;
   endtask

   initial begin
      gl = '{640, 16, 96, 48, 480, 10, 2, 33};
      gs = '{16, 2, 4, 3, 6, 1, 2, 1};
      tab[0]  = '{0,   19'd0,   10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      tab[1]  = '{1,   19'd1,   10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      tab[2]  = '{2,   19'd2,   10'h000, 10'h000, 10'h000, 1'b1, 1'b1};
      tab[3]  = '{3,   19'd3,   10'h000, 10'h000, 10'h3FF, 1'b1, 1'b1};
      tab[4]  = '{7,   19'd7,   10'h3FF, 10'h000, 10'h3FF, 1'b1, 1'b1};
      tab[5]  = '{641, 19'd640, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1, 1'b1};
      tab[6]  = '{642, 19'd640, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      tab[7]  = '{657, 19'd640, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      tab[8]  = '{658, 19'd640, 10'h000, 10'h000, 10'h000, 1'b0, 1'b0};
      tab[9]  = '{753, 19'd640, 10'h000, 10'h000, 10'h000, 1'b0, 1'b0};
      tab[10] = '{754, 19'd640, 10'h000, 10'h000, 10'h000, 1'b1, 1'b0};
      tab[11] = '{802, 19'd642, 10'h000, 10'h000, 10'h000, 1'b1, 1'b1};
      tab[12] = '{804, 19'd644, 10'h000, 10'h3FF, 10'h000, 1'b1, 1'b1};

      // Run A: full-rate scan, q = addr[2:0]
      mode = 0;
      pix_en = 1'b1;
      do_reset();
      hs_low = 0; vs_low = 0; fs_cnt_l = 0; fs_cnt_s = 0;
      for (int i = 0; i < 13; i++) begin
         while (n < tab[i].n) tick_a();
         cmp($sformatf("table_%0d", i),
             53'({rd_l, r_l, g_l, b_l, hs_l, bl_l}),
             53'({tab[i].addr, tab[i].r, tab[i].g, tab[i].b, tab[i].hs_n, tab[i].blank_n}));
      end
      while (n < 1700) tick_a();
      cmp_int("hs_low_per_line", hs_low, 96);
      cmp_int("vs_low_per_frame_small", vs_low, 50);
      cmp_int("frame_start_large", fs_cnt_l, 1);
      cmp_int("frame_start_small", fs_cnt_s, 7);

      // Run B: hashed contents, random / half-rate / paused pix_en, async reset mid-line
      mode = 2;
      seed = int'($urandom_range(0, 1023));
      do_reset();
      for (int i = 0; i < 600; i++) step($urandom_range(0, 3) != 0);
      for (int i = 0; i < 400; i++) step(i[0]);
      for (int i = 0; i < 50; i++) step(1'b0);
      for (int i = 0; i < 200; i++) step(1'b1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n = 0;
      last_tick = 1'b0;
      check_all("async_reset");
      for (int i = 0; i < 3; i++) step(1'b1);
      @(negedge clk);
      pix_en = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) step($urandom_range(0, 1) != 0);

      // Run C: buffer returns all ones, colour must vanish whenever blanked
      mode = 1;
      do_reset();
      bad_mask = 0;
      blank_seen = 0;
      for (int i = 0; i < 600; i++) begin
         step(1'b1);
         if (!bl_s) begin
            blank_seen++;
            if ({r_s, g_s, b_s} != 30'b0) bad_mask++;
         end
      end
      cmp_int("blank_mask_violations", bad_mask, 0);
      cmp_int("blank_seen", int'(blank_seen > 0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
